// File: rtl/rail_sequencer.sv
// rtl/rail_sequencer.sv - parametrised N-rail power sequencer with PG timeout, ordered shutdown and fault latch
module rail_sequencer #(
  parameter int                     NUM_RAILS   = 8,
  parameter int                     RAIL_IDX_W  = 3,
  parameter int                     TIMER_W     = 24,
  parameter logic [TIMER_W-1:0]     STEP_WAIT   = 24'h03_FFFF,
  parameter logic [TIMER_W-1:0]     PG_TIMEOUT  = 24'h3F_FFFF,
  parameter logic [NUM_RAILS-1:0]   PG_MASK     = {NUM_RAILS{1'b1}},
  parameter logic [NUM_RAILS-1:0]   EN_INVERT   = {NUM_RAILS{1'b0}},
  parameter logic [7:0]             PG_DEGLITCH = 8'd4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  power_up,
  input  logic                  power_down,
  input  logic                  fault_clear,
  input  logic [NUM_RAILS-1:0]  rail_pg,
  output logic [NUM_RAILS-1:0]  rail_en,
  output logic [NUM_RAILS-1:0]  rail_on,
  output logic                  power_up_done,
  output logic                  power_down_done,
  output logic                  powered,
  output logic                  busy,
  output logic                  fault,
  output logic [RAIL_IDX_W-1:0] fault_rail,
  output logic [1:0]            fault_cause
);

  typedef enum logic [2:0] {
    S_OFF, S_UP_WAIT_PG, S_UP_SETTLE, S_ON, S_DOWN_STEP, S_FAULT
  } state_t;

  localparam logic [RAIL_IDX_W-1:0] LAST_IDX         = RAIL_IDX_W'(NUM_RAILS - 1);
  localparam logic [1:0]            CAUSE_TIMEOUT    = 2'b01;
  localparam logic [1:0]            CAUSE_PG_LOST    = 2'b10;
  localparam logic [1:0]            CAUSE_EARLY_LOST = 2'b11;

  state_t                  state, state_nxt;
  logic [RAIL_IDX_W-1:0]   idx, idx_nxt;
  logic [TIMER_W-1:0]      timer, timer_nxt;
  logic [NUM_RAILS-1:0]    rail_on_nxt;
  logic [RAIL_IDX_W-1:0]   fault_rail_nxt;
  logic [1:0]              fault_cause_nxt;
  logic                    up_done_nxt, down_done_nxt;

  logic [7:0]              deg_cnt [NUM_RAILS];
  logic [NUM_RAILS-1:0]    pg_ok, early_lost, deg_hit;
  logic                    early_any, deg_any;
  logic [RAIL_IDX_W-1:0]   early_idx, deg_idx;
  logic                    timer_zero, idx_pg_ok;

  assign pg_ok      = rail_pg | ~PG_MASK;
  assign timer_zero = (timer == '0);
  assign idx_pg_ok  = pg_ok[idx];

  // Lowest-index rail wins when several lose PG in the same cycle.
  always_comb begin
    early_lost = '0;
    deg_hit    = '0;
    for (int j = 0; j < NUM_RAILS; j++) begin
      early_lost[j] = ~pg_ok[j] && (RAIL_IDX_W'(j) < idx);
      deg_hit[j]    = ~pg_ok[j] && (deg_cnt[j] >= (PG_DEGLITCH - 8'd1));
    end
    early_any = |early_lost;
    deg_any   = |deg_hit;
    early_idx = '0;
    deg_idx   = '0;
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (early_lost[j]) early_idx = RAIL_IDX_W'(j);
      if (deg_hit[j])    deg_idx   = RAIL_IDX_W'(j);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int j = 0; j < NUM_RAILS; j++) deg_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_RAILS; j++) begin
        if (state != S_ON || pg_ok[j])  deg_cnt[j] <= '0;
        else if (deg_cnt[j] != 8'hFF)   deg_cnt[j] <= deg_cnt[j] + 8'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= S_OFF;
    else             state <= state_nxt;
  end

  // Abort and power_down outrank any fault found in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:        if (!power_down && power_up) state_nxt = S_UP_WAIT_PG;
      S_UP_WAIT_PG: begin
        if (power_down)     state_nxt = S_DOWN_STEP;
        else if (early_any) state_nxt = S_FAULT;
        else if (idx_pg_ok) state_nxt = S_UP_SETTLE;
        else if (timer_zero) state_nxt = S_FAULT;
      end
      S_UP_SETTLE: begin
        if (power_down)      state_nxt = S_DOWN_STEP;
        else if (early_any)  state_nxt = S_FAULT;
        else if (timer_zero) state_nxt = (idx == LAST_IDX) ? S_ON : S_UP_WAIT_PG;
      end
      S_ON: begin
        if (power_down)   state_nxt = S_DOWN_STEP;
        else if (deg_any) state_nxt = S_FAULT;
      end
      S_DOWN_STEP:  if (timer_zero && idx == '0) state_nxt = S_OFF;
      S_FAULT:      if (power_down || fault_clear) state_nxt = S_OFF;
      default:      state_nxt = S_OFF;
    endcase
  end

  always_comb begin
    rail_on_nxt     = rail_on;
    idx_nxt         = idx;
    timer_nxt       = timer_zero ? timer : timer - TIMER_W'(1);
    fault_rail_nxt  = fault_rail;
    fault_cause_nxt = fault_cause;
    up_done_nxt     = 1'b0;
    down_done_nxt   = 1'b0;
    case (state)
      S_OFF: begin
        down_done_nxt = power_down;
        if (state_nxt == S_UP_WAIT_PG) begin
          rail_on_nxt[0] = 1'b1;
          idx_nxt        = '0;
          timer_nxt      = PG_TIMEOUT;
        end
      end
      S_UP_WAIT_PG: if (state_nxt == S_UP_SETTLE) timer_nxt = STEP_WAIT;
      S_UP_SETTLE: begin
        up_done_nxt = (state_nxt == S_ON);
        if (state_nxt == S_UP_WAIT_PG) begin
          idx_nxt              = idx + RAIL_IDX_W'(1);
          rail_on_nxt[idx_nxt] = 1'b1;
          timer_nxt            = PG_TIMEOUT;
        end
      end
      S_DOWN_STEP: begin
        if (state_nxt == S_OFF) down_done_nxt = 1'b1;
        else if (timer_zero) begin
          idx_nxt              = idx - RAIL_IDX_W'(1);
          rail_on_nxt[idx_nxt] = 1'b0;
          timer_nxt            = STEP_WAIT;
        end
      end
      S_FAULT: begin
        if (state_nxt == S_OFF) begin
          fault_rail_nxt  = '0;
          fault_cause_nxt = '0;
          down_done_nxt   = power_down;
        end
      end
      default: ;
    endcase

    if (state_nxt == S_DOWN_STEP && state != S_DOWN_STEP) begin
      idx_nxt              = (state == S_ON) ? LAST_IDX : idx;
      rail_on_nxt[idx_nxt] = 1'b0;
      timer_nxt            = STEP_WAIT;
    end

    // Emergency off: every rail drops together, no ordering.
    if (state_nxt == S_FAULT && state != S_FAULT) begin
      rail_on_nxt = '0;
      if (state == S_ON) begin
        fault_rail_nxt  = deg_idx;
        fault_cause_nxt = CAUSE_PG_LOST;
      end else if (early_any) begin
        fault_rail_nxt  = early_idx;
        fault_cause_nxt = CAUSE_EARLY_LOST;
      end else begin
        fault_rail_nxt  = idx;
        fault_cause_nxt = CAUSE_TIMEOUT;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      rail_on         <= '0;
      idx             <= '0;
      timer           <= '0;
      fault_rail      <= '0;
      fault_cause     <= '0;
      power_up_done   <= 1'b0;
      power_down_done <= 1'b0;
    end else begin
      rail_on         <= rail_on_nxt;
      idx             <= idx_nxt;
      timer           <= timer_nxt;
      fault_rail      <= fault_rail_nxt;
      fault_cause     <= fault_cause_nxt;
      power_up_done   <= up_done_nxt;
      power_down_done <= down_done_nxt;
    end
  end

  always_comb begin
    rail_en = rail_on ^ EN_INVERT;
    powered = (state == S_ON);
    busy    = (state == S_UP_WAIT_PG) || (state == S_UP_SETTLE) || (state == S_DOWN_STEP);
    fault   = (state == S_FAULT);
  end

endmodule

// File: tb/tb_rail_sequencer.sv
// tb/tb_rail_sequencer.sv - directed scoreboard bench for rail_sequencer
module tb_rail_sequencer;

  localparam int N = 4;

  typedef struct packed {
    logic [3:0] val;
    int         gap;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic         a_rst_n, a_up, a_down, a_clr;
  logic [N-1:0] a_pg, a_en, a_on, a_d1, a_d2, a_kill;
  logic         a_pud, a_pdd, a_powered, a_busy, a_fault;
  logic [1:0]   a_frail, a_fcause;

  logic         b_rst_n, b_up, b_down, b_clr;
  logic [N-1:0] b_pg, b_en, b_on, b_d1, b_d2;
  logic         b_pud, b_pdd, b_powered, b_busy, b_fault;
  logic [1:0]   b_frail, b_fcause;

  int a_pud_n = 0, a_pdd_n = 0, b_pud_n = 0, b_pdd_n = 0;

  rail_sequencer #(
    .NUM_RAILS(N), .RAIL_IDX_W(2), .TIMER_W(24),
    .STEP_WAIT(24'd3), .PG_TIMEOUT(24'd10),
    .PG_MASK(4'b1111), .EN_INVERT(4'b0000), .PG_DEGLITCH(8'd2)
  ) dut_a (
    .wb_clk_i(clk), .wb_rst_n_i(a_rst_n),
    .power_up(a_up), .power_down(a_down), .fault_clear(a_clr),
    .rail_pg(a_pg), .rail_en(a_en), .rail_on(a_on),
    .power_up_done(a_pud), .power_down_done(a_pdd),
    .powered(a_powered), .busy(a_busy), .fault(a_fault),
    .fault_rail(a_frail), .fault_cause(a_fcause)
  );

  rail_sequencer #(
    .NUM_RAILS(N), .RAIL_IDX_W(2), .TIMER_W(24),
    .STEP_WAIT(24'd3), .PG_TIMEOUT(24'd10),
    .PG_MASK(4'b0111), .EN_INVERT(4'b1010), .PG_DEGLITCH(8'd2)
  ) dut_b (
    .wb_clk_i(clk), .wb_rst_n_i(b_rst_n),
    .power_up(b_up), .power_down(b_down), .fault_clear(b_clr),
    .rail_pg(b_pg), .rail_en(b_en), .rail_on(b_on),
    .power_up_done(b_pud), .power_down_done(b_pdd),
    .powered(b_powered), .busy(b_busy), .fault(b_fault),
    .fault_rail(b_frail), .fault_cause(b_fcause)
  );

  // PG model: each rail reports good two negedges after its enable.
  always @(negedge clk) begin
    a_d2 = a_d1;
    a_d1 = a_on;
    b_d2 = b_d1;
    b_d1 = b_on;
  end
  assign a_pg = a_d2 & ~a_kill;
  assign b_pg = b_d2 & 4'b0111;

  always @(posedge clk) begin
    if (a_pud === 1'b1) a_pud_n++;
    if (a_pdd === 1'b1) a_pdd_n++;
    if (b_pud === 1'b1) b_pud_n++;
    if (b_pdd === 1'b1) b_pdd_n++;
  end

  step_t      exp_q[$];
  logic [3:0] seen;
  int         last_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] v, input int g);
    step_t s;
    s.val = v;
    s.gap = g;
    exp_q.push_back(s);
  endtask

  task automatic pulse_a(input logic up, input logic dn, input logic clr);
    seen   = a_on;
    a_up   = up;
    a_down = dn;
    a_clr  = clr;
    @(negedge clk);
    a_up   = 1'b0;
    a_down = 1'b0;
    a_clr  = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pops each expected rail_on step and checks value and cycle gap since the previous step.
  task automatic drain(input string tag);
    step_t e;
    int    waited;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (a_on === seen && waited < 64) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      assert (a_on === e.val && (cyc - last_cyc) == e.gap) else begin
        errors++;
        $error("FAIL %s: rail_on=%b gap=%0d expected rail_on=%b gap=%0d",
               tag, a_on, cyc - last_cyc, e.val, e.gap);
      end
      seen     = a_on;
      last_cyc = cyc;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_on3;
    int bound;
    int pud_snap, pdd_snap;
    a_rst_n = 1'b0; a_up = 1'b0; a_down = 1'b0; a_clr = 1'b0; a_kill = '0;
    b_rst_n = 1'b0; b_up = 1'b0; b_down = 1'b0; b_clr = 1'b0;
    a_d1 = '0; a_d2 = '0; b_d1 = '0; b_d2 = '0;
    ticks(3);

    chk("rst_rail_on",     32'(a_on),      32'h0);
    chk("rst_rail_en",     32'(a_en),      32'h0);
    chk("rst_powered",     32'(a_powered), 32'h0);
    chk("rst_busy",        32'(a_busy),    32'h0);
    chk("rst_fault",       32'(a_fault),   32'h0);
    chk("rst_fault_rail",  32'(a_frail),   32'h0);
    chk("rst_fault_cause", 32'(a_fcause),  32'h0);
    chk("rst_b_rail_en",   32'(b_en),      32'hA);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    ticks(1);

    push(4'b0001, 0); push(4'b0011, 6); push(4'b0111, 6); push(4'b1111, 6);
    pulse_a(1'b1, 1'b0, 1'b0);
    drain("t1_up_seq");
    chk("t1_busy", 32'(a_busy), 32'h1);
    ticks(7);
    chk("t1_powered",   32'(a_powered), 32'h1);
    chk("t1_up_done_n", 32'(a_pud_n),   32'd1);

    push(4'b0111, 0); push(4'b0011, 4); push(4'b0001, 4); push(4'b0000, 4);
    pulse_a(1'b0, 1'b1, 1'b0);
    drain("t2_down_seq");
    ticks(6);
    chk("t2_down_done_n", 32'(a_pdd_n),   32'd1);
    chk("t2_powered",     32'(a_powered), 32'h0);
    chk("t2_busy",        32'(a_busy),    32'h0);
    chk("t2_up_done_n",   32'(a_pud_n),   32'd1);

    a_kill = 4'b0100;
    push(4'b0001, 0); push(4'b0011, 6); push(4'b0111, 6); push(4'b0000, 11);
    pulse_a(1'b1, 1'b0, 1'b0);
    drain("t3_timeout_seq");
    chk("t3_fault",       32'(a_fault),  32'h1);
    chk("t3_fault_rail",  32'(a_frail),  32'h2);
    chk("t3_fault_cause", 32'(a_fcause), 32'h1);
    ticks(3);
    chk("t3_fault_held",  32'(a_fault),  32'h1);
    pulse_a(1'b0, 1'b0, 1'b1);
    chk("t3_clr_fault",   32'(a_fault),  32'h0);
    chk("t3_clr_rail",    32'(a_frail),  32'h0);
    chk("t3_clr_cause",   32'(a_fcause), 32'h0);
    chk("t3_clr_busy",    32'(a_busy),   32'h0);
    ticks(2);
    chk("t3_clr_no_strobe", 32'(a_pdd_n), 32'd1);
    a_kill = '0;
    ticks(3);
    push(4'b0001, 0); push(4'b0011, 6); push(4'b0111, 6); push(4'b1111, 6);
    pulse_a(1'b1, 1'b0, 1'b0);
    drain("t3_recover_seq");
    ticks(7);
    chk("t3_recover_powered", 32'(a_powered), 32'h1);
    chk("t3_recover_done_n",  32'(a_pud_n),   32'd2);

    a_kill = 4'b0010;
    ticks(1);
    a_kill = '0;
    ticks(4);
    chk("t4_glitch_no_fault", 32'(a_fault),   32'h0);
    chk("t4_glitch_powered",  32'(a_powered), 32'h1);
    a_kill = 4'b0010;
    ticks(2);
    a_kill = '0;
    chk("t4_fault",       32'(a_fault),  32'h1);
    chk("t4_fault_rail",  32'(a_frail),  32'h1);
    chk("t4_fault_cause", 32'(a_fcause), 32'h2);
    chk("t4_rails_off",   32'(a_on),     32'h0);
    pulse_a(1'b0, 1'b1, 1'b0);
    ticks(2);
    chk("t4_down_done_n", 32'(a_pdd_n),  32'd2);
    chk("t4_fault_exit",  32'(a_fault),  32'h0);
    chk("t4_rail_zeroed", 32'(a_frail),  32'h0);
    chk("t4_cause_zero",  32'(a_fcause), 32'h0);

    ticks(3);
    push(4'b0001, 0); push(4'b0011, 6); push(4'b0111, 6);
    pulse_a(1'b1, 1'b0, 1'b0);
    drain("t5_up_seq");
    ticks(2);
    chk("t5_settle_busy", 32'(a_busy), 32'h1);
    push(4'b0011, 0); push(4'b0001, 4); push(4'b0000, 4);
    pulse_a(1'b0, 1'b1, 1'b0);
    drain("t5_abort_seq");
    ticks(6);
    chk("t5_abort_done_n", 32'(a_pdd_n), 32'd3);
    chk("t5_abort_no_up",  32'(a_pud_n), 32'd2);
    pulse_a(1'b1, 1'b1, 1'b0);
    ticks(2);
    chk("t5_both_down_n", 32'(a_pdd_n), 32'd4);
    chk("t5_both_up_n",   32'(a_pud_n), 32'd2);
    chk("t5_both_off",    32'(a_on),    32'h0);
    chk("t5_both_busy",   32'(a_busy),  32'h0);

    b_up = 1'b1;
    ticks(1);
    b_up = 1'b0;
    bound = 0;
    while (b_on !== 4'b1111 && bound < 100) begin ticks(1); bound++; end
    t_on3 = cyc;
    bound = 0;
    while (b_pud !== 1'b1 && bound < 20) begin ticks(1); bound++; end
    chk("t6_nopg_gap",  32'(cyc - t_on3), 32'd5);
    chk("t6_on_en",     32'(b_en),        32'h5);
    chk("t6_powered",   32'(b_powered),   32'h1);
    b_down = 1'b1;
    ticks(1);
    b_down = 1'b0;
    ticks(20);
    chk("t6_down_done_n", 32'(b_pdd_n), 32'd1);
    chk("t6_off_en",      32'(b_en),    32'hA);
    b_up = 1'b1;
    ticks(1);
    b_up = 1'b0;
    ticks(8);
    chk("t6_mid_rail_on", 32'(b_on),   32'h3);
    chk("t6_mid_busy",    32'(b_busy), 32'h1);
    pud_snap = b_pud_n;
    pdd_snap = b_pdd_n;
    #2;
    b_rst_n = 1'b0;
    #1;
    chk("t6_async_en",   32'(b_en),   32'hA);
    chk("t6_async_on",   32'(b_on),   32'h0);
    chk("t6_async_busy", 32'(b_busy), 32'h0);
    ticks(3);
    b_rst_n = 1'b1;
    ticks(10);
    chk("t6_no_up_strobe",   32'(b_pud_n), 32'(pud_snap));
    chk("t6_no_down_strobe", 32'(b_pdd_n), 32'(pdd_snap));
    chk("t6_idle_on",        32'(b_on),    32'h0);
    chk("t6_idle_fault",     32'(b_fault), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rail_sequencer.md
Name: rail_sequencer

Overview:
Parametrised N-rail power sequencer for the board power manager. It replaces the fixed-order sequencer with a generic engine that has:
- per-rail enable polarity;
- optional per-rail power-good (PG) feedback, with a timeout and a step delay between rails;
- reverse-order shutdown and abort of a power-up in progress;
- deglitched PG-loss fault detection while powered, with the faulting rail and the cause latched.

The power state machine drives it with power_up and power_down strobes and consumes its done, status and fault outputs.

Parameters:
NUM_RAILS, 8, number of sequenced rails; rail 0 powers up first and powers down last.
RAIL_IDX_W, 3, width of the rail index; must satisfy 2^RAIL_IDX_W >= NUM_RAILS.
TIMER_W, 24, width of the shared delay/timeout counter.
STEP_WAIT, 24'h03_FFFF, settle cycles after a rail is good, before the next rail (up) or between rails (down).
PG_TIMEOUT, 24'h3F_FFFF, maximum cycles from a rail enable to its PG asserting.
PG_MASK, {NUM_RAILS{1'b1}}, bit i=1 means rail i has PG feedback; bit i=0 means the rail is treated as good immediately.
EN_INVERT, {NUM_RAILS{1'b0}}, bit i=1 means rail_en[i] is active-low (inhibit style).
PG_DEGLITCH, 8'd4, consecutive PG-low cycles needed to declare a fault in ON; range 1..255.

Ports:
wb_clk_i  in  1  system clock.
wb_rst_n_i  in  1  asynchronous, active-low reset.
power_up  in  1  single-cycle request to start power-up.
power_down  in  1  single-cycle request to start power-down.
fault_clear  in  1  single-cycle request to clear a latched fault.
rail_pg  in  NUM_RAILS  power-good inputs, already synchronised to wb_clk_i.
rail_en  out  NUM_RAILS  enable pins; rail_en[i] = rail_on[i] ^ EN_INVERT[i].
rail_on  out  NUM_RAILS  logical on-state of each rail, registered.
power_up_done  out  1  one-cycle strobe on entry to ON.
power_down_done  out  1  one-cycle strobe on entry to OFF from DOWN, or from FAULT via power_down.
powered  out  1  high while in ON.
busy  out  1  high in UP_WAIT_PG, UP_SETTLE and DOWN_STEP.
fault  out  1  high while in FAULT.
fault_rail  out  RAIL_IDX_W  index of the rail that faulted; held until cleared.
fault_cause  out  2  01 = PG timeout on power-up; 10 = PG lost while ON; 11 = an earlier rail's PG lost during power-up.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State OFF; rail_on = 0, so rail_en = EN_INVERT.
  - All strobes 0; powered, busy and fault 0.
  - fault_rail 0, fault_cause 00; index 0, timer 0.
- States: OFF, UP_WAIT_PG, UP_SETTLE, ON, DOWN_STEP, FAULT.
- Effective PG: pg_ok[i] = rail_pg[i] | ~PG_MASK[i].
- OFF:
  - power_up (with power_down low) at edge k: rail_on[0] = 1 from edge k+1; idx = 0; timer = PG_TIMEOUT; go to UP_WAIT_PG.
  - power_down: power_down_done is strobed the next cycle; stays OFF.
  - power_up and power_down together: power_down wins.
- UP_WAIT_PG:
  - pg_ok[idx] seen: timer = STEP_WAIT; go to UP_SETTLE.
  - Otherwise, timer == 0: go to FAULT with cause 01 and fault_rail = idx.
  - Otherwise decrement the timer.
- UP_SETTLE:
  - timer == 0 and idx == NUM_RAILS-1: go to ON and strobe power_up_done.
  - timer == 0 otherwise: idx+1; set rail_on[idx+1]; timer = PG_TIMEOUT; go to UP_WAIT_PG.
  - Otherwise decrement the timer. STEP_WAIT = 0 advances on the next cycle.
- During UP_WAIT_PG and UP_SETTLE:
  - Any rail j < idx with pg_ok[j] low for one cycle: go to FAULT, cause 11, fault_rail = lowest such j.
  - power_down aborts: go to DOWN_STEP starting at the current idx. Abort outranks a fault detected in the same cycle.
- ON:
  - Per-rail deglitch counter counts consecutive cycles with pg_ok low and resets when pg_ok is high.
  - Counter reaching PG_DEGLITCH: go to FAULT, cause 10, fault_rail = lowest such rail.
  - power_down: go to DOWN_STEP with idx = NUM_RAILS-1 and timer = STEP_WAIT. power_down outranks a fault detected in the same cycle.
  - power_up in ON is ignored.
- DOWN_STEP:
  - On entry, clear rail_on[idx] on the same edge, then wait STEP_WAIT cycles.
  - At timer == 0: if idx == 0 go to OFF and strobe power_down_done; otherwise idx-1, clear that rail, reload the timer.
  - power_up and power_down are ignored (no queueing).
  - PG is not monitored.
- FAULT:
  - Entry clears all rail_on bits on the same edge (emergency off, no ordering) and latches fault_rail and fault_cause.
  - fault_clear: go to OFF with no strobe.
  - power_down: go to OFF and strobe power_down_done.
  - fault, fault_rail and fault_cause are held until FAULT exits. They are then zeroed on that edge.
  - power_up is ignored.
- Timer: unsigned TIMER_W bits, loaded with parameter values, never wraps (decrement only while nonzero).
- Reset mid-sequence: all enables drop immediately and asynchronously. No done strobe is issued.

Test Plan:
1. N=4, STEP_WAIT=3, PG_TIMEOUT=10, every PG returns 2 cycles after enable; power_up -> rail_on 0001, 0011, 0111, 1111 in 6-cycle steps; power_up_done strobes once; powered = 1.
2. From ON: power_down -> rail_on 0111, 0011, 0001, 0000, 4 cycles apart; power_down_done strobes once after the last step; state OFF.
3. Rail 2 PG never asserts -> 11 cycles after rail_on[2], fault = 1, fault_rail = 2, fault_cause = 01, rail_on = 0000; fault_clear -> fault = 0, OFF; power_up works again.
4. ON with PG_DEGLITCH=2: rail 1 PG low for 1 cycle -> no fault; low for 2 cycles -> fault_cause 10, fault_rail 1, all rails off; power_down -> power_down_done strobe.
5. power_up, then power_down while idx=2 in UP_SETTLE -> rails 2, 1, 0 off in reverse order, then power_down_done; power_up and power_down asserted together in OFF -> only power_down_done.
6. EN_INVERT=4'b1010, PG_MASK=4'b0111 -> rail_en after reset = 1010; rail 3 advances without PG; assert wb_rst_n_i low mid power-up -> rail_en returns to 1010 asynchronously, no strobes.
